// File: rtl/bus_initiator.sv
// -----------------------------------------------------------------------------
// bus_initiator
//   Bus master for the as_/cs_/rw/addr/wr_data/rd_data/rdy_ peripheral bus.
//   It accepts one read or write request at a time on a valid/ready port and
//   runs it as a single bus cycle. It then waits for the slave's active-low
//   rdy_. The transfer ends with a one-cycle resp_valid pulse that carries the
//   read data, or it ends with resp_err=1 if the slave does not answer within
//   TIMEOUT cycles.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (accepted only in IDLE)
//   req_rw/addr/wdata     request fields (rw: 1=read, 0=write)
//   resp_valid            one-cycle completion pulse
//   resp_rdata            read data, held until the next resp_valid
//   resp_err              qualifies resp_valid: 1 = timeout abort
//   as_, cs_              address strobe / chip select, active-low
//   rw, addr, wr_data     bus direction, address, write data
//   rd_data, rdy_         slave read data and active-low ready
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module bus_initiator #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              as_,
  output logic              cs_,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rdy_
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic              as_q;
  logic              cs_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // Bus cycle sequencer: the state, the timeout counter and every output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      as_q         <= 1'b1;
      cs_q         <= 1'b1;
      rw_q         <= 1'b1;
      addr_q       <= '0;
      wr_data_q    <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // rdy_ is ignored here: any strobe seen now is stale or unsolicited.
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            rw_q        <= req_rw;
            addr_q      <= req_addr;
            if (!req_rw) begin
              wr_data_q <= req_wdata;
            end
            as_q    <= 1'b0;
            cs_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          // Success is checked first, so a reply on the last allowed cycle still wins.
          if (!rdy_) begin
            if (rw_q) begin
              resp_rdata_q <= rd_data;
            end
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            as_q         <= 1'b1;
            cs_q         <= 1'b1;
            state_q      <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            as_q         <= 1'b1;
            cs_q         <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          // This is the mandatory idle bus cycle. After it, the port accepts requests again.
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          req_ready_q <= 1'b0;
          as_q        <= 1'b1;
          cs_q        <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign as_        = as_q;
  assign cs_        = cs_q;
  assign rw         = rw_q;
  assign addr       = addr_q;
  assign wr_data    = wr_data_q;

endmodule
